fft_mag_buf: RTL and testbench
==============================

Name: fft_mag_buf

Overview:
- Upstream neighbour of the spectrum peak-search stage. Accepts one streamed FFT frame of complex bins, computes an integer magnitude estimate per bin, and stores it in an internal 256x16 buffer.
- Asserts wr_done once the full frame is stored. The downstream peak search then reads bins through a synchronous read port.
- Holds the frame, with wr_done high, until the consumer pulses clear.

Parameters:
- N_FFT, 256, bins per frame and buffer depth (power of two)
- AW, 8, address width, log2(N_FFT)
- DW, 16, input component width and magnitude width

Ports:
- clk_256k  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  FFT output beat valid
- s_ready  out  1  block accepts beat this cycle
- s_last  in  1  last bin of frame, qualified by s_valid
- s_re  in  DW  signed real part, two's complement
- s_im  in  DW  signed imaginary part, two's complement
- clear  in  1  single-cycle pulse: release frame, rearm for next
- rd_addr  in  AW  buffer read address from peak search
- rd_data  out  DW  magnitude at rd_addr, registered
- wr_done  out  1  level: complete frame held in buffer
- frame_err  out  1  one-cycle pulse on malformed frame

Behaviour:
- Reset values: s_ready=0, wr_done=0, frame_err=0, rd_data=0, write index=0, state=COLLECT. Buffer contents are undefined after reset.
- Beat accepted when s_valid and s_ready are both high.
- Magnitude estimate, 3-stage pipeline from accept to buffer write:
  - Stage 1: a=|s_re|, b=|s_im|, both 16-bit unsigned; |-32768|=32768.
  - Stage 2: mx=max(a,b), mn=min(a,b).
  - Stage 3: mag = mx + (mn>>2) + (mn>>3), truncating shifts.
  - Worst case is 45056, so the result fits DW with no saturation.
- Write address is the accept index: 0 .. N_FFT-1.
- States:
  - COLLECT: s_ready=1.
    - Accept with s_last and index==N_FFT-1 -> FLUSH.
    - Accept with s_last and index<N_FFT-1 -> frame_err pulse, index:=0, stay in COLLECT. Pipelined writes still land.
    - Accept at index==N_FFT-1 without s_last -> frame_err pulse, go to RESYNC.
  - RESYNC: s_ready=1, beats dropped (not written). Accept with s_last -> index:=0, COLLECT.
  - FLUSH: s_ready=0 until the pipeline drains (3 cycles after the last accept). Then wr_done:=1 and go to DONE. The last bin is written before wr_done rises.
  - DONE: s_ready=0, wr_done=1, buffer frozen.
    - clear -> wr_done:=0 next cycle, index:=0, COLLECT.
- clear received in COLLECT, RESYNC or FLUSH: abort. Pipeline writes are squashed, index:=0, go to COLLECT, no frame_err.
- Read port is always active. rd_data <= mem[rd_addr] every cycle, so data is valid one cycle after the address.
- Same-address read/write in one cycle returns old data. This cannot occur while wr_done=1.
- Asynchronous reset mid-frame drops the partial frame. wr_done stays 0 until a full frame completes.
- Back-to-back beats sustain one bin per cycle. s_valid gaps stall nothing: pipeline stages carry a valid bit.

Decomposition:
- Shared package fft_pkg:
  - state enum {COLLECT, RESYNC, FLUSH, DONE}
  - N_FFT / AW / DW defaults
  - magnitude shift constants MAG_SH1=2, MAG_SH2=3, also used by the test reference model
- Natural sub-module: mag_est.
  - 3-stage abs/max-min/sum pipeline with valid and address sideband.
  - Has a squash input for clear.
- Buffer and FSM stay in fft_mag_buf.

Test Plan:
- Single bin check: stream 256 beats, all (0,0) except bin 10 = (3000,-4000).
  - rd_addr=10 -> rd_data=5125 one cycle later; other bins read 0.
  - wr_done rises 3 cycles after the last accept.
- Extremes: bin 5=(-32768,-32768) -> 45056 (0xB000); bin 6=(32767,0) -> 32767; bin 7=(-1,1) -> 1.
- Early s_last: s_last on beat index 99 -> frame_err pulse one cycle, wr_done stays 0. A following clean 256-beat frame -> wr_done=1, contents match the second frame.
- Missing s_last: 256 beats with no s_last, then 3 junk beats ending in s_last.
  - frame_err pulse at the 256th beat; junk beats not written.
  - Next clean frame completes normally.
- Hold and clear: while wr_done=1, s_ready=0 and s_valid stays high with new data -> buffer unchanged. clear pulse -> wr_done=0 next cycle, s_ready=1, next frame overwrites.
- Reset mid-frame: assert rst_n=0 at beat 128 -> all outputs 0. Release and send a full frame -> wr_done after 256 accepts + 3 cycles.

Source files
------------

// File: rtl/fft_mag_buf_pkg.sv
// Shared types and constants for the FFT magnitude buffer.
// Imported by the buffer, its pipeline and the bench reference model.
package fft_pkg;

  localparam int N_FFT   = 256;
  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int MAG_SH1 = 2;
  localparam int MAG_SH2 = 3;

  typedef enum logic [1:0] {
    COLLECT,
    RESYNC,
    FLUSH,
    DONE
  } state_t;

  // Two's complement magnitude; the most negative value maps to 2^(DW-1).
  function automatic logic [DW-1:0] uabs(input logic [DW-1:0] x);
    return x[DW-1] ? (~x + DW'(1)) : x;
  endfunction

endpackage

// File: rtl/fft_mag_buf_if.sv
// Streamed FFT bin handshake between the FFT core and the magnitude buffer.
// The master drives the beat, the slave returns ready.
interface fft_mag_buf_if;
  import fft_pkg::*;

  logic                 s_valid;
  logic                 s_ready;
  logic                 s_last;
  logic signed [DW-1:0] s_re;
  logic signed [DW-1:0] s_im;

  modport master (
    output s_valid,
    output s_last,
    output s_re,
    output s_im,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_last,
    input  s_re,
    input  s_im,
    output s_ready
  );

endinterface

// File: rtl/fft_mag_buf_mag_est.sv
// Abs / max-min / shift-add magnitude pipeline.
// Stages 1-2 are registered; stage 3 sum feeds the buffer write port.
module mag_est
  import fft_pkg::*;
(
  input  logic          clk_256k,
  input  logic          rst_n,
  input  logic          squash,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_mag,
  output logic          busy
);

  logic          v1, v2;
  logic [AW-1:0] ad1, ad2;
  logic [DW-1:0] a1, b1;
  logic [DW-1:0] mx2, mn2;

  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      ad1 <= '0;
      ad2 <= '0;
      a1  <= '0;
      b1  <= '0;
      mx2 <= '0;
      mn2 <= '0;
    end else begin
      v1  <= in_valid & ~squash;
      v2  <= v1 & ~squash;
      ad1 <= in_addr;
      ad2 <= ad1;
      a1  <= uabs(in_re);
      b1  <= uabs(in_im);
      mx2 <= (a1 >= b1) ? a1 : b1;
      mn2 <= (a1 >= b1) ? b1 : a1;
    end
  end

  // Worst case 45056 fits DW, so no saturation is needed.
  assign out_mag   = mx2 + (mn2 >> MAG_SH1) + (mn2 >> MAG_SH2);
  assign out_valid = v2 & ~squash;
  assign out_addr  = ad2;
  assign busy      = v1 | v2;

endmodule

// File: rtl/fft_mag_buf.sv
// Collects one FFT frame of magnitudes into a 256x16 buffer.
// Holds it with wr_done high until the consumer pulses clear.
module fft_mag_buf
  import fft_pkg::*;
(
  input  logic          clk_256k,
  input  logic          rst_n,
  fft_mag_buf_if.slave  up,
  input  logic          clear,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          wr_done,
  output logic          frame_err
);

  state_t        state_q, state_n;
  logic [AW-1:0] idx_q, idx_n;
  logic          ready_q;
  logic          err_n;
  logic          pipe_in;
  logic          acc;
  logic          last_idx;

  logic          est_valid;
  logic [AW-1:0] est_addr;
  logic [DW-1:0] est_mag;
  logic          est_busy;

  logic [DW-1:0] mem [N_FFT];

  assign acc      = up.s_valid & ready_q;
  assign last_idx = (idx_q == AW'(N_FFT - 1));

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    err_n   = 1'b0;
    pipe_in = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (clear) begin
          idx_n = '0;
        end else if (acc) begin
          pipe_in = 1'b1;
          if (up.s_last) begin
            idx_n = '0;
            if (last_idx) state_n = FLUSH;
            else          err_n   = 1'b1;
          end else if (last_idx) begin
            idx_n   = '0;
            err_n   = 1'b1;
            state_n = RESYNC;
          end else begin
            idx_n = idx_q + AW'(1);
          end
        end
      end
      RESYNC: begin
        if (clear || (acc && up.s_last)) begin
          idx_n   = '0;
          state_n = COLLECT;
        end
      end
      FLUSH: begin
        if (clear) begin
          idx_n   = '0;
          state_n = COLLECT;
        end else if (!est_busy) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (clear) begin
          idx_n   = '0;
          state_n = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      ready_q   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      ready_q   <= (state_n == COLLECT) || (state_n == RESYNC);
      frame_err <= err_n;
    end
  end

  assign up.s_ready = ready_q;
  assign wr_done    = (state_q == DONE);

  mag_est u_mag_est (
    .clk_256k  (clk_256k),
    .rst_n     (rst_n),
    .squash    (clear),
    .in_valid  (pipe_in),
    .in_addr   (idx_q),
    .in_re     (up.s_re),
    .in_im     (up.s_im),
    .out_valid (est_valid),
    .out_addr  (est_addr),
    .out_mag   (est_mag),
    .busy      (est_busy)
  );

  always_ff @(posedge clk_256k) begin
    if (est_valid) mem[est_addr] <= est_mag;
  end

  // Same-address read during a write returns the old word.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_fft_mag_buf.sv
// Scoreboard bench for fft_mag_buf: directed frames, read-back via queue,
// frame error, hold/clear and mid-frame reset scenarios.
module tb_fft_mag_buf;
  import fft_pkg::*;

  logic          clk_256k = 1'b0;
  logic          rst_n    = 1'b0;
  logic          clear    = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic [DW-1:0] rd_data;
  logic          wr_done;
  logic          frame_err;

  fft_mag_buf_if bus ();

  always #5 clk_256k = ~clk_256k;

  fft_mag_buf dut (
    .clk_256k  (clk_256k),
    .rst_n     (rst_n),
    .up        (bus.slave),
    .clear     (clear),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_done   (wr_done),
    .frame_err (frame_err)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int addr_q[$];
  int fre[N_FFT];
  int fim[N_FFT];

  logic rd_v   = 1'b0;
  logic rd_v_q = 1'b0;

  always @(posedge clk_256k) rd_v_q <= rd_v;

  // Monitor: a read issued last cycle presents rd_data now.
  always @(negedge clk_256k) begin
    if (rd_v_q) begin
      int e;
      int a;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got %0d want none", rd_data);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (rd_data !== DW'(e)) begin
          failures++;
          $display("FAIL rd[%0d] got %0d want %0d", a, rd_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic drive_beat(input int re, input int im, input logic last);
    int n;
    @(negedge clk_256k);
    bus.s_valid = 1'b1;
    bus.s_re    = DW'(re);
    bus.s_im    = DW'(im);
    bus.s_last  = last;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk_256k);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk_256k);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) drive_beat(fre[i], fim[i], i == last_at);
  endtask

  task automatic expect_done(input string nm);
    idle();
    chk({nm, "_done_c0"}, int'(wr_done), 0);
    chk({nm, "_ready_flush"}, int'(bus.s_ready), 0);
    @(negedge clk_256k);
    chk({nm, "_done_c1"}, int'(wr_done), 0);
    @(negedge clk_256k);
    chk({nm, "_done_c2"}, int'(wr_done), 0);
    @(negedge clk_256k);
    chk({nm, "_done_c3"}, int'(wr_done), 1);
  endtask

  task automatic rd(input int a, input int e);
    @(negedge clk_256k);
    rd_addr = AW'(a);
    rd_v    = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
  endtask

  task automatic rd_end();
    @(negedge clk_256k);
    rd_v = 1'b0;
    @(negedge clk_256k);
  endtask

  task automatic pulse_clear();
    @(negedge clk_256k);
    bus.s_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk_256k);
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_re    = '0;
    bus.s_im    = '0;

    #12;
    chk("rst_ready", int'(bus.s_ready), 0);
    chk("rst_done", int'(wr_done), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_rd", int'(rd_data), 0);
    @(negedge clk_256k);
    rst_n = 1'b1;
    @(negedge clk_256k);
    chk("post_rst_ready", int'(bus.s_ready), 1);

    // Single bin plus extremes
    for (int i = 0; i < N_FFT; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
    fre[10] = 3000;   fim[10] = -4000;
    fre[5]  = -32768; fim[5]  = -32768;
    fre[6]  = 32767;
    fre[7]  = -1;     fim[7]  = 1;
    send_frame(256, 255);
    expect_done("a");
    rd(10, 5125);
    rd(5, 45056);
    rd(6, 32767);
    rd(7, 1);
    rd(0, 0);
    rd(11, 0);
    rd(255, 0);
    rd_end();

    // Hold while done: new beats must be refused
    @(negedge clk_256k);
    bus.s_valid = 1'b1;
    bus.s_re    = DW'(1000);
    bus.s_im    = '0;
    bus.s_last  = 1'b0;
    repeat (4) @(negedge clk_256k);
    chk("hold_ready", int'(bus.s_ready), 0);
    chk("hold_done", int'(wr_done), 1);
    rd(10, 5125);
    rd(0, 0);
    rd_end();
    pulse_clear();
    chk("clear_done", int'(wr_done), 0);
    chk("clear_ready", int'(bus.s_ready), 1);

    // Early s_last on index 99
    for (int i = 0; i < N_FFT; i++) begin
      fre[i] = i;
      fim[i] = 0;
    end
    send_frame(100, 99);
    idle();
    chk("early_err", int'(frame_err), 1);
    chk("early_done", int'(wr_done), 0);
    @(negedge clk_256k);
    chk("early_err_pulse", int'(frame_err), 0);

    for (int i = 0; i < N_FFT; i++) begin
      fre[i] = 3 * i;
      fim[i] = -i;
    end
    send_frame(256, 255);
    expect_done("c");
    rd(0, 0);
    rd(50, 168);
    rd(99, 333);
    rd(200, 675);
    rd(255, 859);
    rd_end();
    pulse_clear();

    // Missing s_last, then junk beats ending in s_last
    for (int i = 0; i < N_FFT; i++) begin
      fre[i] = 7;
      fim[i] = 7;
    end
    send_frame(256, -1);
    idle();
    chk("miss_err", int'(frame_err), 1);
    chk("miss_ready", int'(bus.s_ready), 1);
    @(negedge clk_256k);
    chk("miss_err_pulse", int'(frame_err), 0);
    drive_beat(1000, 1000, 1'b0);
    drive_beat(1000, 1000, 1'b0);
    drive_beat(1000, 1000, 1'b1);
    idle();
    repeat (3) @(negedge clk_256k);
    rd(0, 8);
    rd(1, 8);
    rd(2, 8);
    rd(255, 8);
    rd_end();
    chk("miss_done", int'(wr_done), 0);

    for (int i = 0; i < N_FFT; i++) begin
      fre[i] = -i;
      fim[i] = 2 * i;
    end
    send_frame(256, 255);
    expect_done("d");
    rd(0, 0);
    rd(1, 2);
    rd(100, 237);
    rd(255, 604);
    rd_end();
    pulse_clear();

    // Reset in the middle of a frame
    for (int i = 0; i < N_FFT; i++) begin
      fre[i] = 500;
      fim[i] = 500;
    end
    send_frame(128, -1);
    @(negedge clk_256k);
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk("mrst_ready", int'(bus.s_ready), 0);
    chk("mrst_done", int'(wr_done), 0);
    chk("mrst_err", int'(frame_err), 0);
    chk("mrst_rd", int'(rd_data), 0);
    @(negedge clk_256k);
    rst_n = 1'b1;

    for (int i = 0; i < N_FFT; i++) begin
      fre[i] = i + 1000;
      fim[i] = -i;
    end
    send_frame(256, 255);
    expect_done("f");
    rd(0, 1000);
    rd(128, 1176);
    rd(255, 1349);
    rd_end();

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
